// File: rtl/lfsr_param_if.sv
// Control and status bundle for lfsr_param: the step/load requests and
// the LFSR state plus its pulse outputs.
interface lfsr_param_if #(
  parameter int WIDTH = 12
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] lfsr_out;
  logic             max_tick;
  logic [WIDTH-1:0] period_out;
  logic             period_valid;
  logic             load_err;

  modport master (
    output en, load, seed_in,
    input  lfsr_out, max_tick, period_out, period_valid, load_err
  );

  modport slave (
    input  en, load, seed_in,
    output lfsr_out, max_tick, period_out, period_valid, load_err
  );
endinterface

// File: rtl/lfsr_param.sv
// Parametrised Fibonacci LFSR with seed load, zero-seed rejection and
// measurement of the number of steps taken to return to the active seed.
module lfsr_param #(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] TAPS  = 12'h829,
  parameter logic [WIDTH-1:0] SEED  = 12'h001
) (
  input logic         CCLK,
  input logic         reset,
  lfsr_param_if.slave bus
);

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_step_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_max_tick;
  logic             r_period_valid;
  logic             r_load_err;

  logic             w_fb;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_step_inc;

  logic [WIDTH-1:0] w_lfsr_next;
  logic [WIDTH-1:0] w_seed_next;
  logic [WIDTH-1:0] w_step_cnt_next;
  logic [WIDTH-1:0] w_period_next;
  logic             w_max_tick_next;
  logic             w_period_valid_next;
  logic             w_load_err_next;

  assign w_fb       = ^(r_lfsr & TAPS);
  assign w_shift    = {r_lfsr[WIDTH-2:0], w_fb};
  // Wraps modulo 2^WIDTH; a maximal period of 2^WIDTH-1 still fits.
  assign w_step_inc = r_step_cnt + WIDTH'(1);

  always_comb begin
    w_lfsr_next         = r_lfsr;
    w_seed_next         = r_seed;
    w_step_cnt_next     = r_step_cnt;
    w_period_next       = r_period;
    w_max_tick_next     = 1'b0;
    w_period_valid_next = 1'b0;
    w_load_err_next     = 1'b0;

    if (bus.load) begin
      w_step_cnt_next = '0;
      // A zero seed would lock the register up, so fall back to SEED.
      if (bus.seed_in != '0) begin
        w_lfsr_next = bus.seed_in;
        w_seed_next = bus.seed_in;
      end else begin
        w_lfsr_next     = SEED;
        w_seed_next     = SEED;
        w_load_err_next = 1'b1;
      end
    end else if (bus.en) begin
      w_lfsr_next = w_shift;
      if (w_shift == r_seed) begin
        w_max_tick_next     = 1'b1;
        w_period_valid_next = 1'b1;
        w_period_next       = w_step_inc;
        w_step_cnt_next     = '0;
      end else begin
        w_step_cnt_next = w_step_inc;
      end
    end
  end

  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      r_lfsr         <= SEED;
      r_seed         <= SEED;
      r_step_cnt     <= '0;
      r_period       <= '0;
      r_max_tick     <= 1'b0;
      r_period_valid <= 1'b0;
      r_load_err     <= 1'b0;
    end else begin
      r_lfsr         <= w_lfsr_next;
      r_seed         <= w_seed_next;
      r_step_cnt     <= w_step_cnt_next;
      r_period       <= w_period_next;
      r_max_tick     <= w_max_tick_next;
      r_period_valid <= w_period_valid_next;
      r_load_err     <= w_load_err_next;
    end
  end

  assign bus.lfsr_out     = r_lfsr;
  assign bus.max_tick     = r_max_tick;
  assign bus.period_out   = r_period;
  assign bus.period_valid = r_period_valid;
  assign bus.load_err     = r_load_err;

endmodule

// File: tb/tb_lfsr_param.sv
// Bench for lfsr_param: default 12-bit instance plus a 4-bit short-period
// instance, both compared every cycle against a behavioural model.
module tb_lfsr_param;

  localparam int               W_A    = 12;
  localparam logic [W_A-1:0]   TAPS_A = 12'h829;
  localparam logic [W_A-1:0]   SEED_A = 12'h001;
  localparam int               W_B    = 4;
  localparam logic [W_B-1:0]   TAPS_B = 4'hF;
  localparam logic [W_B-1:0]   SEED_B = 4'h1;

  // Tap masks lacking the top bit can reach the all-zero state.
  if (!TAPS_A[W_A-1] || !TAPS_B[W_B-1]) begin : g_bad_taps
    initial begin
      $display("FAIL taps_msb: tap mask lacks bit WIDTH-1");
      $fatal(1, "illegal TAPS");
    end
  end

  logic CCLK = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  always #5 CCLK = ~CCLK;

  lfsr_param_if #(.WIDTH(W_A)) bus_a ();
  lfsr_param_if #(.WIDTH(W_B)) bus_b ();

  lfsr_param #(.WIDTH(W_A), .TAPS(TAPS_A), .SEED(SEED_A)) dut_a (
    .CCLK(CCLK), .reset(rst_a_n), .bus(bus_a.slave));
  lfsr_param #(.WIDTH(W_B), .TAPS(TAPS_B), .SEED(SEED_B)) dut_b (
    .CCLK(CCLK), .reset(rst_b_n), .bus(bus_b.slave));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model, one slot per instance.
  logic [31:0] m_state [2];
  logic [31:0] m_seed  [2];
  logic [31:0] m_cnt   [2];
  logic [31:0] m_period[2];
  bit          m_tick  [2];
  bit          m_err   [2];

  function automatic logic [31:0] p_mask(input int d);
    return (d == 0) ? 32'h0000_0FFF : 32'h0000_000F;
  endfunction
  function automatic logic [31:0] p_taps(input int d);
    return (d == 0) ? 32'(TAPS_A) : 32'(TAPS_B);
  endfunction
  function automatic logic [31:0] p_seed(input int d);
    return (d == 0) ? 32'(SEED_A) : 32'(SEED_B);
  endfunction

  // Shift left by one (doubling modulo 2^W) and append the tap parity.
  function automatic logic [31:0] next_of(input int d, input logic [31:0] s);
    logic [31:0] par;
    par = 32'($countones(s & p_taps(d)) % 2);
    return ((s * 2) & p_mask(d)) + par;
  endfunction

  task automatic model_reset(input int d);
    m_state[d] = p_seed(d); m_seed[d] = p_seed(d);
    m_cnt[d] = 0; m_period[d] = 0; m_tick[d] = 0; m_err[d] = 0;
  endtask

  task automatic get_out(input int d, output logic [31:0] lf, output logic [31:0] per,
                         output logic tk, output logic pv, output logic le);
    if (d == 0) begin
      lf = 32'(bus_a.lfsr_out); per = 32'(bus_a.period_out);
      tk = bus_a.max_tick; pv = bus_a.period_valid; le = bus_a.load_err;
    end else begin
      lf = 32'(bus_b.lfsr_out); per = 32'(bus_b.period_out);
      tk = bus_b.max_tick; pv = bus_b.period_valid; le = bus_b.load_err;
    end
  endtask

  task automatic check_dut(input int d);
    logic [31:0] lf, per;
    logic tk, pv, le;
    get_out(d, lf, per, tk, pv, le);
    chk($sformatf("d%0d_lfsr", d),   lf, m_state[d]);
    chk($sformatf("d%0d_period", d), per, m_period[d]);
    chk($sformatf("d%0d_tick", d),   32'(tk), 32'(m_tick[d]));
    chk($sformatf("d%0d_pvalid", d), 32'(pv), 32'(m_tick[d]));
    chk($sformatf("d%0d_lerr", d),   32'(le), 32'(m_err[d]));
  endtask

  // One clock of stimulus on instance d, then model update and compare.
  task automatic cycle(input int d, input bit e, input bit l, input logic [31:0] s);
    logic [31:0] n;
    if (d == 0) begin
      bus_a.en = e; bus_a.load = l; bus_a.seed_in = s[W_A-1:0];
    end else begin
      bus_b.en = e; bus_b.load = l; bus_b.seed_in = s[W_B-1:0];
    end
    @(posedge CCLK);
    #1;
    m_tick[d] = 0;
    m_err[d]  = 0;
    if (l) begin
      m_cnt[d] = 0;
      if (s == 0) begin
        m_state[d] = p_seed(d); m_seed[d] = p_seed(d); m_err[d] = 1;
      end else begin
        m_state[d] = s; m_seed[d] = s;
      end
    end else if (e) begin
      n = next_of(d, m_state[d]);
      m_state[d] = n;
      if (n == m_seed[d]) begin
        m_tick[d] = 1;
        m_period[d] = (m_cnt[d] + 1) & p_mask(d);
        m_cnt[d] = 0;
      end else begin
        m_cnt[d] = (m_cnt[d] + 1) & p_mask(d);
      end
    end
    check_dut(d);
  endtask

  initial begin
    int steps;
    int cyc;
    bit got;
    bit e;
    logic [31:0] seq [4];
    seq[0] = 32'h003; seq[1] = 32'h007; seq[2] = 32'h00F; seq[3] = 32'h01E;

    bus_a.en = 0; bus_a.load = 0; bus_a.seed_in = '0;
    bus_b.en = 0; bus_b.load = 0; bus_b.seed_in = '0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge CCLK);
    #1;
    check_dut(0);
    rst_a_n = 1'b1;
    $display("reset released on instance A, lfsr_out=0x%0h", bus_a.lfsr_out);

    // First steps from the reset seed.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0);
      chk($sformatf("seq%0d", i), 32'(bus_a.lfsr_out), seq[i]);
    end

    // Continuous run: first wrap at 4095 total steps, second 4095 later.
    steps = 4;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      cycle(0, 1, 0, 0);
      steps++;
      got = bus_a.max_tick;
    end
    chk("first_tick_step", 32'(steps), 32'd4095);
    chk("first_period", 32'(bus_a.period_out), 32'd4095);
    chk("first_wrap_lfsr", 32'(bus_a.lfsr_out), 32'h001);
    $display("first wrap after %0d steps, period_out=%0d", steps, bus_a.period_out);
    steps = 0;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      cycle(0, 1, 0, 0);
      steps++;
      got = bus_a.max_tick;
    end
    chk("second_tick_gap", 32'(steps), 32'd4095);
    $display("second wrap after %0d more steps", steps);

    // Random enable: wrap after 4095 enabled steps only.
    steps = 0;
    got = 0;
    for (int i = 0; i < 12000 && !got; i++) begin
      e = 1'($urandom_range(0, 1));
      cycle(0, e, 0, 0);
      if (e) steps++;
      got = bus_a.max_tick;
    end
    chk("rand_en_steps", 32'(steps), 32'd4095);
    $display("random-enable wrap after %0d enabled steps", steps);

    // Load with en also high: load wins, new seed becomes the wrap target.
    repeat (10) cycle(0, 1, 0, 0);
    cycle(0, 1, 1, 32'h0A5);
    chk("load_lfsr", 32'(bus_a.lfsr_out), 32'h0A5);
    chk("load_no_tick", 32'(bus_a.max_tick), 32'd0);
    steps = 0;
    got = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      cycle(0, 1, 0, 0);
      steps++;
      got = bus_a.max_tick;
    end
    chk("seed_a5_steps", 32'(steps), 32'd4095);
    chk("seed_a5_lfsr", 32'(bus_a.lfsr_out), 32'h0A5);
    chk("seed_a5_period", 32'(bus_a.period_out), 32'd4095);
    $display("seed 0x0A5 wrap after %0d steps", steps);

    // Zero seed rejected.
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 32'h0);
    chk("zero_load_err", 32'(bus_a.load_err), 32'd1);
    chk("zero_load_lfsr", 32'(bus_a.lfsr_out), 32'h001);
    chk("zero_load_tick", 32'(bus_a.max_tick), 32'd0);
    cycle(0, 0, 0, 0);
    chk("zero_load_err_drop", 32'(bus_a.load_err), 32'd0);
    $display("zero seed load: lfsr_out=0x%0h", bus_a.lfsr_out);

    // Short-period 4-bit instance.
    check_dut(1);
    rst_b_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 0);
      chk("b_nonzero", 32'(bus_b.lfsr_out != 0), 32'd1);
      if (bus_b.period_valid) begin
        chk("b_period5", 32'(bus_b.period_out), 32'd5);
        $display("instance B period_valid, period_out=%0d", bus_b.period_out);
      end
    end
    repeat (2) cycle(1, 1, 0, 0);
    #3;
    rst_b_n = 1'b0;
    #1;
    model_reset(1);
    check_dut(1);
    @(posedge CCLK);
    #1;
    check_dut(1);
    rst_b_n = 1'b1;
    $display("instance B async reset mid-period, lfsr_out=0x%0h", bus_b.lfsr_out);
    steps = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1, 1, 0, 0);
      steps++;
      got = bus_b.period_valid;
    end
    chk("b_post_reset_steps", 32'(steps), 32'd5);
    chk("b_post_reset_period", 32'(bus_b.period_out), 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
Name: lfsr_param

Overview:
- Parametrised Fibonacci LFSR; successor to the fixed 12-bit LFSR top.
- Adds generic width and taps, step enable, runtime seed load, all-zero lock-up protection, and period measurement.
- Used as a pseudo-random source and as a self-checking period generator for the display/test datapaths.

Parameters:
WIDTH, 12, register width; legal range 3..32.
TAPS, 12'h829, feedback tap mask (bit i set = state[i] feeds XOR); default is x^12+x^6+x^4+x+1, maximal length.
SEED, 12'h001, reset and fallback seed; must be nonzero.

Ports:
CCLK  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
en  input  1  advance LFSR one step this cycle.
load  input  1  load seed_in this cycle; takes priority over en.
seed_in  input  WIDTH  seed value sampled when load=1.
lfsr_out  output  WIDTH  current LFSR state (registered).
max_tick  output  1  one-cycle pulse; state has returned to the active seed.
period_out  output  WIDTH  steps in the last completed cycle (registered).
period_valid  output  1  one-cycle pulse, coincident with max_tick; period_out updated.
load_err  output  1  one-cycle pulse; an all-zero seed was rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - lfsr_out=SEED, seed_reg=SEED, step_cnt=0, period_out=0.
  - max_tick=0, period_valid=0, load_err=0.
- Feedback and next state:
  - fb = XOR-reduce(lfsr_out & TAPS).
  - next = {lfsr_out[WIDTH-2:0], fb}, i.e. shift left with fb into bit 0.
- Per-cycle priority: load > en > hold.
- load=1, seed_in nonzero:
  - lfsr_out<=seed_in; seed_reg<=seed_in; step_cnt<=0.
  - No max_tick or period_valid this cycle.
- load=1, seed_in==0:
  - lfsr_out<=SEED; seed_reg<=SEED; step_cnt<=0; load_err<=1 for one cycle.
- en=1, load=0:
  - lfsr_out<=next; step_cnt<=step_cnt+1.
  - If next==seed_reg: max_tick<=1, period_valid<=1, period_out<=step_cnt+1, step_cnt<=0. All of these are visible in the same cycle that lfsr_out shows the seed again.
- en=0, load=0:
  - All state held; pulse outputs return to 0.
- Pulse outputs (max_tick, period_valid, load_err):
  - Registered; high for exactly one cycle per event.
  - Return to 0 on the next cycle unless a new event occurs.
- Counter width:
  - step_cnt and period_out are WIDTH bits; a maximal sequence of 2^WIDTH-1 steps fits exactly.
  - For a non-maximal TAPS, step_cnt wraps modulo 2^WIDTH. No saturation is required because the cycle length is always <= 2^WIDTH-1.
- Lock-up: an all-zero state is unreachable.
  - SEED is nonzero, and zero seeds are replaced by SEED.
  - With a nonzero state, next is never zero for any TAPS that includes bit WIDTH-1.
  - TAPS without bit WIDTH-1 is illegal configuration; the bench checks for it with an elaboration assertion.
- Reset mid-operation: everything returns to the reset values immediately, independent of CCLK.
- Latency: 1 cycle from load/en at a CCLK edge to the updated lfsr_out. Status outputs carry the same latency.

Test Plan:
- Default params; release reset after 2 cycles; en=1 → lfsr_out sequence 0x001, 0x003, 0x007, 0x00F, 0x01E on successive edges.
- Default params; en=1 continuously → first max_tick and period_valid 4095 cycles after the first step, with period_out=4095 and lfsr_out=0x001; the second pulse arrives exactly 4095 cycles later.
- Toggle en with a 50% random pattern → lfsr_out changes only on en=1 cycles; max_tick appears after 4095 enabled steps.
- load=1 with seed_in=0x0A5 mid-run, load and en high together → lfsr_out=0x0A5 next cycle, en ignored; the next max_tick occurs when lfsr_out returns to 0x0A5, with period_out=4095.
- load=1 with seed_in=0 → load_err pulses for one cycle; lfsr_out=0x001; no max_tick.
- WIDTH=4, TAPS=4'hF, SEED=4'h1, en=1 → period_out=5 on each period_valid; lfsr_out never 0. Assert reset mid-period → outputs return to reset values asynchronously, and after release the first period_valid again reports 5.
